// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home alarm stages.
// Holds the arming state encoding and the tamper/exit-timer widths.
package smart_home_pkg;

  typedef enum logic [1:0] {
    DISARMED   = 2'b00,
    EXIT_DELAY = 2'b01,
    ARMED      = 2'b10,
    LOCKOUT    = 2'b11
  } arm_state_t;

  localparam int TAMPER_W     = 4;
  localparam logic [TAMPER_W-1:0] TAMPER_MAX = 4'd15;
  localparam int EXIT_TIMER_W = 16;

  // Saturating increment: the tamper count must never wrap back to zero.
  function automatic logic [TAMPER_W-1:0] sat_inc(input logic [TAMPER_W-1:0] value);
    if (value == TAMPER_MAX) begin
      sat_inc = TAMPER_MAX;
    end else begin
      sat_inc = value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
// The pulse is one cycle wide and appears two clocks after the input rises.
module sync_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/alarm_arm_controller.sv
// Arming FSM with exit-delay timer and tamper supervision.
// Produces the enable qualifier and tamper count consumed by the motion alarm stage.
module alarm_arm_controller
  import smart_home_pkg::*;
#(
  parameter int EXIT_CYCLES  = 1000,
  parameter int TAMPER_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       systemOn,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       clear_tamper,
  input  logic       tamper_raw,
  output logic       enable,
  output logic [3:0] tamper_counter,
  output logic       lockout,
  output logic       exit_pending,
  output logic [1:0] arm_state
);

  localparam logic [EXIT_TIMER_W-1:0] EXIT_LOAD = EXIT_TIMER_W'(EXIT_CYCLES - 1);
  localparam logic [TAMPER_W-1:0]     LIMIT     = TAMPER_W'(TAMPER_LIMIT);

  arm_state_t              state_r;
  arm_state_t              state_nxt_s;
  logic [EXIT_TIMER_W-1:0] timer_r;
  logic [EXIT_TIMER_W-1:0] timer_nxt_s;
  logic [TAMPER_W-1:0]     count_r;
  logic [TAMPER_W-1:0]     count_nxt_s;
  logic                    tamper_edge_s;
  logic                    enable_r;
  logic                    lockout_r;
  logic                    exit_pending_r;

  sync_edge_detector u_tamper_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tamper_raw),
    .pulse (tamper_edge_s)
  );

  // State, timer, counter and decoded output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= DISARMED;
      timer_r        <= {EXIT_TIMER_W{1'b0}};
      count_r        <= {TAMPER_W{1'b0}};
      enable_r       <= 1'b0;
      lockout_r      <= 1'b0;
      exit_pending_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      timer_r        <= timer_nxt_s;
      count_r        <= count_nxt_s;
      enable_r       <= (state_nxt_s == ARMED) || (state_nxt_s == LOCKOUT);
      lockout_r      <= (state_nxt_s == LOCKOUT);
      exit_pending_r <= (state_nxt_s == EXIT_DELAY);
    end
  end

  // Tamper count: power-off clears, clear_tamper keeps a coincident edge, else saturating count.
  always_comb begin
    count_nxt_s = count_r;
    if (!systemOn) begin
      count_nxt_s = {TAMPER_W{1'b0}};
    end else if (clear_tamper && (state_r != LOCKOUT)) begin
      count_nxt_s = tamper_edge_s ? 4'd1 : 4'd0;
    end else if (tamper_edge_s) begin
      count_nxt_s = sat_inc(count_r);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Next-state logic; the limit check uses the registered count so lockout trails the count by one edge.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    if (!systemOn) begin
      state_nxt_s = DISARMED;
      timer_nxt_s = {EXIT_TIMER_W{1'b0}};
    end else if (count_r >= LIMIT) begin
      state_nxt_s = LOCKOUT;
    end else begin
      case (state_r)
        DISARMED: begin
          if (arm_req && !disarm_req) begin
            state_nxt_s = EXIT_DELAY;
            timer_nxt_s = EXIT_LOAD;
          end else begin
            state_nxt_s = DISARMED;
          end
        end
        EXIT_DELAY: begin
          if (disarm_req) begin
            state_nxt_s = DISARMED;
            timer_nxt_s = {EXIT_TIMER_W{1'b0}};
          end else if (timer_r == {EXIT_TIMER_W{1'b0}}) begin
            state_nxt_s = ARMED;
          end else begin
            timer_nxt_s = timer_r - 16'd1;
          end
        end
        ARMED: begin
          if (disarm_req) begin
            state_nxt_s = DISARMED;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        LOCKOUT: begin
          state_nxt_s = LOCKOUT;
        end
        default: begin
          state_nxt_s = DISARMED;
          timer_nxt_s = {EXIT_TIMER_W{1'b0}};
        end
      endcase
    end
  end

  assign enable         = enable_r;
  assign lockout        = lockout_r;
  assign exit_pending   = exit_pending_r;
  assign tamper_counter = count_r;
  assign arm_state      = state_r;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Randomised and directed bench for alarm_arm_controller, two instances with different parameters
// driven from the same inputs and checked against a behavioural model.
module tb_alarm_arm_controller;

  localparam int EXC [2] = '{4, 1};
  localparam int LIM [2] = '{3, 15};

  logic clk = 1'b0;
  logic rst_n, sys_on, arm, dis, clr, raw;
  logic       a_en, a_lk, a_ex, b_en, b_lk, b_ex;
  logic [3:0] a_cnt, b_cnt;
  logic [1:0] a_st, b_st;
  logic [8:0] obs [2];

  int total = 0;
  int bad   = 0;

  // model: mode 0=off,1=counting down,2=armed,3=locked
  int m_mode [2];
  int m_rem  [2];
  int m_cnt  [2];
  bit h1, h2, h3;

  always #5 clk = ~clk;

  alarm_arm_controller #(.EXIT_CYCLES(4), .TAMPER_LIMIT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .systemOn(sys_on), .arm_req(arm), .disarm_req(dis),
    .clear_tamper(clr), .tamper_raw(raw), .enable(a_en), .tamper_counter(a_cnt),
    .lockout(a_lk), .exit_pending(a_ex), .arm_state(a_st));

  alarm_arm_controller #(.EXIT_CYCLES(1), .TAMPER_LIMIT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .systemOn(sys_on), .arm_req(arm), .disarm_req(dis),
    .clear_tamper(clr), .tamper_raw(raw), .enable(b_en), .tamper_counter(b_cnt),
    .lockout(b_lk), .exit_pending(b_ex), .arm_state(b_st));

  assign obs[0] = {a_en, a_ex, a_lk, a_st, a_cnt};
  assign obs[1] = {b_en, b_ex, b_lk, b_st, b_cnt};

  function automatic logic [8:0] exp_vec(input int i);
    logic [1:0] st;
    logic [3:0] c;
    st = 2'(m_mode[i]);
    c  = 4'(m_cnt[i]);
    return {m_mode[i] >= 2, m_mode[i] == 1, m_mode[i] == 3, st, c};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_rem[i] = 0; m_cnt[i] = 0;
    end
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_edge();
    bit edge_now;
    int old_cnt;
    // a tamper edge is seen when raw was high two edges ago and low three edges ago
    edge_now = h2 && !h3;
    for (int i = 0; i < 2; i++) begin
      old_cnt = m_cnt[i];
      if (!sys_on) m_cnt[i] = 0;
      else if (clr && m_mode[i] != 3) m_cnt[i] = edge_now ? 1 : 0;
      else if (edge_now && m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
      if (!sys_on) m_mode[i] = 0;
      else if (old_cnt >= LIM[i]) m_mode[i] = 3;
      else if (m_mode[i] == 3) m_mode[i] = 3;
      else if (dis && (m_mode[i] == 1 || m_mode[i] == 2)) m_mode[i] = 0;
      else if (m_mode[i] == 0 && arm && !dis) begin
        m_mode[i] = 1; m_rem[i] = EXC[i];
      end else if (m_mode[i] == 1) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) m_mode[i] = 2;
      end
    end
    h3 = h2; h2 = h1; h1 = raw;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic idle_inputs();
    arm = 1'b0; dis = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sys_on = 1'b0; raw = 1'b0; idle_inputs();
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 9'd0) begin
        bad++; $display("FAIL reset inst%0d got=%b exp=%b", i, obs[i], 9'd0);
      end
    end
    rst_n = 1'b1; sys_on = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    total++;
    if (a_ex !== 1'b1 || b_ex !== 1'b1) begin
      bad++; $display("FAIL arm_first_edge a_ex=%b b_ex=%b exp=1", a_ex, b_ex);
    end
    for (int j = 1; j < 4; j++) begin
      step();
      total++;
      if (a_ex !== 1'b1 || a_en !== 1'b0) begin
        bad++; $display("FAIL arm_delay j=%0d ex=%b en=%b exp ex=1 en=0", j, a_ex, a_en);
      end
      if (j == 1) begin
        total++;
        if (b_en !== 1'b1 || b_st !== 2'b10) begin
          bad++; $display("FAIL arm_exit1 en=%b st=%b exp en=1 st=10", b_en, b_st);
        end
      end
    end
    step();
    total++;
    if (a_en !== 1'b1 || a_ex !== 1'b0 || a_st !== 2'b10) begin
      bad++; $display("FAIL arm_done en=%b ex=%b st=%b exp 1 0 10", a_en, a_ex, a_st);
    end
    dis = 1'b1;
    step();
    dis = 1'b0;
    total++;
    if (a_en !== 1'b0 || a_st !== 2'b00) begin
      bad++; $display("FAIL disarm_armed en=%b st=%b exp 0 00", a_en, a_st);
    end
  endtask

  task automatic test_disarm_mid_exit();
    arm = 1'b1; step(); arm = 1'b0;
    step();
    dis = 1'b1; arm = 1'b1; step(); dis = 1'b0; arm = 1'b0;
    total++;
    if (a_st !== 2'b00 || a_ex !== 1'b0) begin
      bad++; $display("FAIL disarm_mid st=%b ex=%b exp 00 0", a_st, a_ex);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      total++;
      if (a_en !== 1'b0) begin
        bad++; $display("FAIL disarm_no_enable j=%0d en=%b exp=0", j, a_en);
      end
    end
    // arm and disarm together from DISARMED stays DISARMED
    arm = 1'b1; dis = 1'b1; step(); idle_inputs();
    total++;
    if (obs[0] !== exp_vec(0) || a_st !== 2'b00) begin
      bad++; $display("FAIL arm_dis_race got=%b exp=%b", obs[0], exp_vec(0));
    end
  endtask

  task automatic pulse_tamper(input int hi, input int lo);
    raw = 1'b1;
    repeat (hi) step();
    raw = 1'b0;
    repeat (lo) step();
  endtask

  task automatic test_tamper_lockout();
    for (int p = 0; p < 3; p++) begin
      raw = 1'b1;
      for (int j = 0; j < 6; j++) begin
        if (j == 3) raw = 1'b0;
        step();
        total++;
        if (obs[0] !== exp_vec(0) || obs[1] !== exp_vec(1)) begin
          bad++; $display("FAIL tamper_step p=%0d j=%0d a=%b/%b b=%b/%b", p, j, obs[0], exp_vec(0), obs[1], exp_vec(1));
        end
      end
      total++;
      if (a_cnt !== 4'(p + 1)) begin
        bad++; $display("FAIL tamper_count p=%0d got=%0d exp=%0d", p, a_cnt, p + 1);
      end
    end
    total++;
    if (a_lk !== 1'b1 || a_en !== 1'b1 || a_st !== 2'b11) begin
      bad++; $display("FAIL lockout lk=%b en=%b st=%b exp 1 1 11", a_lk, a_en, a_st);
    end
    dis = 1'b1; clr = 1'b1; arm = 1'b1; step(); idle_inputs();
    step();
    total++;
    if (a_lk !== 1'b1 || a_cnt !== 4'd3 || b_cnt !== 4'd0) begin
      bad++; $display("FAIL lockout_ignore lk=%b acnt=%0d bcnt=%0d exp 1 3 0", a_lk, a_cnt, b_cnt);
    end
  endtask

  task automatic test_lockout_exit();
    sys_on = 1'b0; step(); sys_on = 1'b1;
    total++;
    if (a_st !== 2'b00 || a_cnt !== 4'd0 || a_lk !== 1'b0 || a_en !== 1'b0) begin
      bad++; $display("FAIL lockout_exit st=%b cnt=%0d lk=%b en=%b exp 00 0 0 0", a_st, a_cnt, a_lk, a_en);
    end
    step();
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 16; p++) pulse_tamper(3, 3);
    repeat (2) step();
    total++;
    if (b_cnt !== 4'd15 || b_lk !== 1'b1 || a_cnt !== 4'd15) begin
      bad++; $display("FAIL saturation bcnt=%0d blk=%b acnt=%0d exp 15 1 15", b_cnt, b_lk, a_cnt);
    end
  endtask

  task automatic test_clear_race();
    sys_on = 1'b0; step(); sys_on = 1'b1;
    for (int p = 0; p < 5; p++) pulse_tamper(3, 3);
    total++;
    if (b_cnt !== 4'd5) begin
      bad++; $display("FAIL race_setup got=%0d exp=5", b_cnt);
    end
    raw = 1'b1;
    step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    total++;
    if (b_cnt !== 4'd1 || obs[0] !== exp_vec(0)) begin
      bad++; $display("FAIL clear_race bcnt=%0d exp=1 a=%b/%b", b_cnt, obs[0], exp_vec(0));
    end
    raw = 1'b0; repeat (3) step();
  endtask

  task automatic test_async_reset_armed();
    sys_on = 1'b0; step(); sys_on = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    repeat (5) step();
    total++;
    if (a_st !== 2'b10 || a_en !== 1'b1) begin
      bad++; $display("FAIL pre_reset_armed st=%b en=%b exp 10 1", a_st, a_en);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (a_en !== 1'b0 || a_st !== 2'b00 || b_en !== 1'b0 || obs[0] !== 9'd0) begin
      bad++; $display("FAIL async_reset en=%b st=%b ben=%b exp 0 00 0", a_en, a_st, b_en);
    end
    step(); step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      arm    = ($urandom_range(0, 7) == 0);
      dis    = ($urandom_range(0, 15) == 0);
      clr    = ($urandom_range(0, 29) == 0);
      sys_on = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) raw = ~raw;
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          bad++; $display("FAIL random n=%0d inst%0d got=%b exp=%b", n, i, obs[i], exp_vec(i));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_arm();
    test_disarm_mid_exit();
    test_tamper_lockout();
    test_lockout_exit();
    test_saturation();
    test_clear_race();
    test_async_reset_armed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
